// File: rtl/riscv_pkg.sv
// Shared types for the RV32I core pipeline control.
// Holds the base opcode map, the write-back source and forwarding-select
// encodings, the hazard controller state set and the halt cause codes.
package riscv_pkg;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Register write-back source carried with each instruction
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_DM  = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  // EX operand source select
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_PC4 = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_e;

  typedef enum logic [1:0] {
    HC_NONE       = 2'b00,
    HC_ILLEGAL    = 2'b01,
    HC_DM_TIMEOUT = 2'b10
  } halt_cause_e;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one source operand (purely combinational).
// Ports:
//   ex_rs_i        source register of the EX instruction for this operand
//   mem_rd_i       destination of the instruction in MEM
//   mem_ru_write_i MEM instruction writes the register file
//   mem_wb_src_i   MEM write-back source
//   wb_rd_i        destination of the instruction in WB
//   wb_ru_write_i  WB instruction writes the register file
//   fwd_o          operand select (RF / WB / MEM ALU / MEM PC+4)
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_ru_write_i,
  input  logic [1:0] mem_wb_src_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_ru_write_i,
  output fwd_sel_e   fwd_o
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hard-wired zero and is never forwarded
  assign mem_hit = mem_ru_write_i & (mem_rd_i == ex_rs_i) & (ex_rs_i != '0);
  assign wb_hit  = wb_ru_write_i & (wb_rd_i == ex_rs_i) & (ex_rs_i != '0);

  // A load sitting in MEM has no result yet; the load-use stall keeps a
  // consumer out of EX in that case, so it simply falls through to WB/RF.
  always_comb begin
    fwd_o = FWD_RF;
    if (mem_hit && (mem_wb_src_i == WB_ALU)) begin
      fwd_o = FWD_MEM;
    end else if (mem_hit && (mem_wb_src_i == WB_PC4)) begin
      fwd_o = FWD_PC4;
    end else if (wb_hit) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core.
// Drives per-stage register enables/flushes from load-use hazards, taken
// redirects, data-memory wait states and illegal opcodes; selects EX operand
// forwarding; keeps saturating stall/flush counters.
// Ports:
//   clk, rst                         clock, async active-high reset
//   id_rs1/id_rs2, id_use1/id_use2   ID sources and their use flags
//   id_illegal                       ID holds an undecodable opcode
//   ex_rs1/ex_rs2/ex_rd              EX register fields
//   ex_ru_write, ex_wb_src           EX write-back control
//   ex_br_taken                      branch unit redirect
//   mem_rd/mem_ru_write/mem_wb_src   MEM write-back control
//   wb_rd/wb_ru_write                WB write-back control
//   mem_dm_access, dm_ready          data-memory handshake
//   pc_en..mem_wb_en                 stage register load enables
//   if_id_flush/id_ex_flush/mem_wb_flush  bubble insertion
//   fwd_a, fwd_b                     EX operand selects
//   halted, halt_cause               fatal stop status
//   stall_cycles, flush_events       saturating event counters
module pipe_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_illegal,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_ru_write,
  input  logic [1:0]       ex_wb_src,
  input  logic             ex_br_taken,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_ru_write,
  input  logic [1:0]       mem_wb_src,
  input  logic             wb_ru_write,
  input  logic             mem_dm_access,
  input  logic             dm_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned WAIT_W = $clog2(DM_TIMEOUT + 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  halt_cause_e       halt_cause_q, halt_cause_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic     freeze;
  logic     load_use;
  fwd_sel_e fwd_a_sel;
  fwd_sel_e fwd_b_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign freeze   = mem_dm_access & ~dm_ready;
  assign load_use = ex_ru_write & (ex_wb_src == WB_DM) & (ex_rd != '0) &
                    ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));

  // RUN and MEM_WAIT share the unfrozen path: the release cycle of a wait
  // is an ordinary cycle, so a redirect held in EX during the freeze (or a
  // load-use / illegal opcode) is acted on there.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    halt_cause_d = halt_cause_q;
    stall_d      = stall_q;
    flush_d      = flush_q;

    case (state_q)
      HALT: begin
      end
      default: begin
        if (freeze) begin
          // Only WB moves on; it is refilled with a bubble so it retires once
          mem_wb_en    = 1'b1;
          mem_wb_flush = 1'b1;
          stall_d      = sat_inc(stall_q);
          if (state_q == RUN) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if (wait_cnt_q == WAIT_W'(DM_TIMEOUT)) begin
            state_d      = HALT;
            halt_cause_d = HC_DM_TIMEOUT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          pc_en      = 1'b1;
          if_id_en   = 1'b1;
          id_ex_en   = 1'b1;
          ex_mem_en  = 1'b1;
          mem_wb_en  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
          if (ex_br_taken) begin
            // ID instruction is wrong-path, so its illegal flag is ignored
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_d     = sat_inc(flush_q);
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_d     = sat_inc(stall_q);
          end else if (id_illegal) begin
            state_d      = HALT;
            halt_cause_d = HC_ILLEGAL;
          end
        end
      end
    endcase

    // Reset holds every stage register loading bubbles
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      halt_cause_q <= HC_NONE;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      halt_cause_q <= halt_cause_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end

  fwd_unit u_fwd_a (
    .ex_rs_i        (ex_rs1),
    .mem_rd_i       (mem_rd),
    .mem_ru_write_i (mem_ru_write),
    .mem_wb_src_i   (mem_wb_src),
    .wb_rd_i        (wb_rd),
    .wb_ru_write_i  (wb_ru_write),
    .fwd_o          (fwd_a_sel)
  );

  fwd_unit u_fwd_b (
    .ex_rs_i        (ex_rs2),
    .mem_rd_i       (mem_rd),
    .mem_ru_write_i (mem_ru_write),
    .mem_wb_src_i   (mem_wb_src),
    .wb_rd_i        (wb_rd),
    .wb_ru_write_i  (wb_ru_write),
    .fwd_o          (fwd_b_sel)
  );

  assign fwd_a        = fwd_a_sel;
  assign fwd_b        = fwd_b_sel;
  assign halted       = (state_q == HALT);
  assign halt_cause   = halt_cause_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule
